// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with overlap policy, one-shot halt,
// sample-enable gating, synchronous re-arm and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned      N       = 4,
  parameter logic [N-1:0]     PATTERN = 4'b1001,
  parameter int unsigned      OVERLAP = 1,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x,
  input  logic             en,
  input  logic             mode,
  input  logic             clear,
  output logic             y,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned FILL_W = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(N);

  typedef enum logic {
    SEARCH = 1'b0,
    DONE   = 1'b1
  } state_t;

  state_t             r_state, w_state_n;
  logic [N-1:0]       r_hist, w_hist_n, w_shift;
  logic [FILL_W-1:0]  r_fill, w_fill_n, w_fill_inc;
  logic               r_y, w_y_n;
  logic               r_done, w_done_n;
  logic [CNT_W-1:0]   r_count, w_count_n;
  logic               w_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEARCH;
      r_hist  <= '0;
      r_fill  <= '0;
      r_y     <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_n;
      r_hist  <= w_hist_n;
      r_fill  <= w_fill_n;
      r_y     <= w_y_n;
      r_done  <= w_done_n;
      r_count <= w_count_n;
    end
  end

  // fill gates the compare so zeroed history never matches an all-zero PATTERN
  always_comb begin
    w_shift    = {r_hist[N-2:0], x};
    w_fill_inc = (r_fill == FULL) ? FULL : r_fill + 1'b1;
    w_hit      = (w_fill_inc == FULL) && (w_shift == PATTERN);
  end

  always_comb begin
    w_state_n = r_state;
    w_hist_n  = r_hist;
    w_fill_n  = r_fill;
    w_y_n     = 1'b0;
    w_done_n  = r_done;
    w_count_n = r_count;
    if (clear) begin
      w_state_n = SEARCH;
      w_hist_n  = '0;
      w_fill_n  = '0;
      w_done_n  = 1'b0;
      w_count_n = '0;
    end else if (r_state == SEARCH && en) begin
      w_hist_n = w_shift;
      w_fill_n = w_fill_inc;
      if (w_hit) begin
        w_y_n     = 1'b1;
        w_count_n = (r_count == '1) ? r_count : r_count + 1'b1;
        w_fill_n  = (OVERLAP != 0) ? FULL : '0;
        if (mode) begin
          w_state_n = DONE;
          w_done_n  = 1'b1;
        end
      end
    end
  end

  assign y           = r_y;
  assign done        = r_done;
  assign match_count = r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three builds share one stimulus stream and are
// checked every cycle against a queue-based model of the detection rules.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic x = 1'b0, en = 1'b0, mode = 1'b0, clear = 1'b0;

  logic       y0, y1, y2, d0, d1, d2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  always #5 clk = ~clk;

  seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk(clk), .reset_n(reset_n), .x(x), .en(en), .mode(mode), .clear(clear),
    .y(y0), .done(d0), .match_count(c0));
  seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(0), .CNT_W(8)) dut_nov (
    .clk(clk), .reset_n(reset_n), .x(x), .en(en), .mode(mode), .clear(clear),
    .y(y1), .done(d1), .match_count(c1));
  seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset_n(reset_n), .x(x), .en(en), .mode(mode), .clear(clear),
    .y(y2), .done(d2), .match_count(c2));

  int errors = 0;
  int checks = 0;

  // Model state: bits sampled since last reset/clear/non-overlap match, oldest first.
  bit          mq[3][$];
  bit          my[3];
  bit          mdone[3];
  int unsigned mcnt[3];
  int unsigned mmax[3] = '{255, 255, 3};
  bit          mov[3]  = '{1'b1, 1'b0, 1'b1};
  logic [3:0]  pat = 4'b1001;
  bit          model_live = 1'b0;
  int          pulses2 = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      my[k] = 1'b0;
      mdone[k] = 1'b0;
      mcnt[k] = 0;
    end
  endtask

  task automatic model_edge(input bit xb, input bit enb, input bit modeb, input bit clrb);
    bit hit;
    for (int k = 0; k < 3; k++) begin
      my[k] = 1'b0;
      if (clrb) begin
        mq[k].delete();
        mdone[k] = 1'b0;
        mcnt[k] = 0;
      end else if (!mdone[k] && enb) begin
        mq[k].push_back(xb);
        if (mq[k].size() > 4) void'(mq[k].pop_front());
        hit = (mq[k].size() == 4);
        for (int i = 0; i < mq[k].size(); i++)
          if (mq[k][i] != pat[3-i]) hit = 1'b0;
        if (hit) begin
          my[k] = 1'b1;
          if (mcnt[k] < mmax[k]) mcnt[k]++;
          if (!mov[k]) mq[k].delete();
          if (modeb) mdone[k] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      chk("y_ov",     int'(y0), int'(my[0]));
      chk("done_ov",  int'(d0), int'(mdone[0]));
      chk("cnt_ov",   int'(c0), int'(mcnt[0]));
      chk("y_nov",    int'(y1), int'(my[1]));
      chk("done_nov", int'(d1), int'(mdone[1]));
      chk("cnt_nov",  int'(c1), int'(mcnt[1]));
      chk("y_c2",     int'(y2), int'(my[2]));
      chk("done_c2",  int'(d2), int'(mdone[2]));
      chk("cnt_c2",   int'(c2), int'(mcnt[2]));
      if (y2) pulses2++;
    end
  end

  task automatic step(input bit xb, input bit enb, input bit modeb, input bit clrb);
    x = xb; en = enb; mode = modeb; clear = clrb;
    @(posedge clk);
    model_edge(xb, enb, modeb, clrb);
    @(negedge clk);
    #1;
  endtask

  task automatic stream(input logic [31:0] bits, input int len, input bit modeb);
    for (int i = len - 1; i >= 0; i--) step(bits[i], 1'b1, modeb, 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      x = ~x;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask

  task automatic pulse_clear();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_clear();
    en = 1'b1;
    @(negedge clk);
    model_live = 1'b1;

    // 1. reset held with x toggling, then a partial pattern
    do_reset(4);
    chk("rst_y", int'(y0), 0);
    chk("rst_done", int'(d0), 0);
    chk("rst_cnt", int'(c0), 0);
    stream(32'b100, 3, 1'b0);
    chk("partial_y", int'(y0), 0);

    // 2/3. overlap vs non-overlap on 1001001
    pulse_clear();
    stream(32'b1001, 4, 1'b0);
    chk("ov_y_4th", int'(y0), 1);
    chk("nov_y_4th", int'(y1), 1);
    stream(32'b001, 3, 1'b0);
    chk("ov_y_7th", int'(y0), 1);
    chk("nov_y_7th", int'(y1), 0);
    chk("ov_cnt2", int'(c0), 2);
    chk("nov_cnt1", int'(c1), 1);
    pulse_clear();
    stream(32'b10011001, 8, 1'b0);
    chk("nov_cnt2", int'(c1), 2);

    // 4. one-shot halts, clear re-arms
    pulse_clear();
    stream(32'b10011001, 8, 1'b1);
    chk("os_done", int'(d0), 1);
    chk("os_cnt", int'(c0), 1);
    pulse_clear();
    chk("os_clr_done", int'(d0), 0);
    chk("os_clr_cnt", int'(c0), 0);
    stream(32'b1001, 4, 1'b1);
    chk("os_rearm_y", int'(y0), 1);

    // 5. en gating: disabled cycles must not shift history
    pulse_clear();
    stream(32'b10, 2, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    stream(32'b01, 2, 1'b0);
    chk("en_y", int'(y0), 1);
    chk("en_cnt", int'(c0), 1);

    // 6a. counter saturation on the CNT_W=2 build
    pulse_clear();
    pulses2 = 0;
    stream(32'b1001001001001001, 16, 1'b0);
    chk("sat_cnt", int'(c2), 3);
    chk("sat_pulses", pulses2, 5);
    chk("sat_wide_cnt", int'(c0), 5);

    // 6b. reset mid-pattern loses partial history
    pulse_clear();
    stream(32'b100, 3, 1'b0);
    do_reset(1);
    stream(32'b1, 1, 1'b0);
    chk("midrst_y", int'(y0), 0);

    // 6c. clear on the edge of the final bit wins
    pulse_clear();
    stream(32'b100, 3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clrhit_y", int'(y0), 0);
    chk("clrhit_cnt", int'(c0), 0);

    model_live = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
